// File: rtl/pipe_stage_regs.sv
// Pipeline registers for the 5-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Handles hazard stalls, which hold IF/ID and inject an ID/EX bubble.
// Handles branch/jump squash, which turns the IF/ID entry into a NOP.
// Also keeps saturating stall/flush counters and a sticky runaway-stall flag.
module pipe_stage_regs #(
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
  parameter int          MAX_STALL = 2,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instrIF,
  input  logic [31:0]      pcIF,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      aluEX_Result,
  input  logic [31:0]      EX_StoreData,
  input  logic [31:0]      MEM_RdData,
  output logic             pc_en,
  output logic [31:0]      instrIFID,
  output logic [31:0]      instrIDEX,
  output logic [31:0]      instrEXMEM,
  output logic [31:0]      instrMEMWB,
  output logic [31:0]      pcIFID,
  output logic [31:0]      pcIDEX,
  output logic             vIFID,
  output logic             vIDEX,
  output logic             vEXMEM,
  output logic             vMEMWB,
  output logic [31:0]      aluEXMEM_Data,
  output logic [31:0]      aluMEMWB_Data,
  output logic [31:0]      EXMEM_Data2Mem,
  output logic [31:0]      MEMWB_MemData,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_err
);

  // The consecutive-stall counter only needs to reach MAX_STALL; it parks there.
  localparam int                 CONS_W   = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [CONS_W-1:0]  CONS_MAX = CONS_W'(MAX_STALL);

  logic [CONS_W-1:0] consec;

  // Fetch is frozen exactly while the hazard unit stalls.
  assign pc_en = !stall;

  // IF/ID: hold on stall, squash on flush (stall takes priority), else capture fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instrIFID <= NOP_WORD;
      pcIFID    <= '0;
      vIFID     <= 1'b0;
    end else if (!stall) begin
      if (flush) begin
        instrIFID <= NOP_WORD;
        pcIFID    <= '0;
        vIFID     <= 1'b0;
      end else begin
        instrIFID <= instrIF;
        pcIFID    <= pcIF;
        vIFID     <= 1'b1;
      end
    end
  end

  // ID/EX: bubble on stall; otherwise take IF/ID, which on a flush is the branch itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instrIDEX <= NOP_WORD;
      pcIDEX    <= '0;
      vIDEX     <= 1'b0;
    end else if (stall) begin
      instrIDEX <= NOP_WORD;
      pcIDEX    <= '0;
      vIDEX     <= 1'b0;
    end else begin
      instrIDEX <= instrIFID;
      pcIDEX    <= pcIFID;
      vIDEX     <= vIFID;
    end
  end

  // EX/MEM and MEM/WB always advance; data words load unconditionally, qualified by v*.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instrEXMEM     <= NOP_WORD;
      vEXMEM         <= 1'b0;
      aluEXMEM_Data  <= '0;
      EXMEM_Data2Mem <= '0;
      instrMEMWB     <= NOP_WORD;
      vMEMWB         <= 1'b0;
      aluMEMWB_Data  <= '0;
      MEMWB_MemData  <= '0;
    end else begin
      instrEXMEM     <= instrIDEX;
      vEXMEM         <= vIDEX;
      aluEXMEM_Data  <= aluEX_Result;
      EXMEM_Data2Mem <= EX_StoreData;
      instrMEMWB     <= instrEXMEM;
      vMEMWB         <= vEXMEM;
      aluMEMWB_Data  <= aluEXMEM_Data;
      MEMWB_MemData  <= MEM_RdData;
    end
  end

  // Saturating event counters; a flush masked by a stall is not counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && !stall && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  // Runaway detection: a stall arriving after MAX_STALL stalled edges sets the sticky flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      consec    <= '0;
      stall_err <= 1'b0;
    end else if (stall) begin
      if (consec >= CONS_MAX) begin
        stall_err <= 1'b1;
      end else begin
        consec <= consec + CONS_W'(1);
      end
    end else begin
      consec <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: reset, advance, load-use stall, flush,
// stall+flush priority, data path, runaway flag and counter saturation.
module tb_pipe_stage_regs;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      instrIF, pcIF;
  logic             stall, flush;
  logic [31:0]      aluEX_Result, EX_StoreData, MEM_RdData;
  logic             pc_en;
  logic [31:0]      instrIFID, instrIDEX, instrEXMEM, instrMEMWB;
  logic [31:0]      pcIFID, pcIDEX;
  logic             vIFID, vIDEX, vEXMEM, vMEMWB;
  logic [31:0]      aluEXMEM_Data, aluMEMWB_Data, EXMEM_Data2Mem, MEMWB_MemData;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             stall_err;

  int n_checks = 0;
  int n_fails  = 0;

  pipe_stage_regs #(
    .NOP_WORD (32'h0000_0000),
    .MAX_STALL(2),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instrIF       (instrIF),
    .pcIF          (pcIF),
    .stall         (stall),
    .flush         (flush),
    .aluEX_Result  (aluEX_Result),
    .EX_StoreData  (EX_StoreData),
    .MEM_RdData    (MEM_RdData),
    .pc_en         (pc_en),
    .instrIFID     (instrIFID),
    .instrIDEX     (instrIDEX),
    .instrEXMEM    (instrEXMEM),
    .instrMEMWB    (instrMEMWB),
    .pcIFID        (pcIFID),
    .pcIDEX        (pcIDEX),
    .vIFID         (vIFID),
    .vIDEX         (vIDEX),
    .vEXMEM        (vEXMEM),
    .vMEMWB        (vMEMWB),
    .aluEXMEM_Data (aluEXMEM_Data),
    .aluMEMWB_Data (aluMEMWB_Data),
    .EXMEM_Data2Mem(EXMEM_Data2Mem),
    .MEMWB_MemData (MEMWB_MemData),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt),
    .stall_err     (stall_err)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADDI = 32'h2009_0005;
  localparam logic [31:0] I_LW   = 32'h8C09_0004;
  localparam logic [31:0] I_ADD  = 32'h012A_5820;
  localparam logic [31:0] I_BR   = 32'h1C22_0003;

  initial begin
    rst_n = 1'b0; instrIF = I_ADDI; pcIF = 32'h0000_0004;
    stall = 1'b1; flush = 1'b0;
    aluEX_Result = '0; EX_StoreData = '0; MEM_RdData = '0;

    // Reset hold with stall asserted: reset wins.
    step(); step();
    check("rst_instrIFID", instrIFID, 32'h0);
    check("rst_instrMEMWB", instrMEMWB, 32'h0);
    check("rst_valids", {28'h0, vIFID, vIDEX, vEXMEM, vMEMWB}, 32'h0);
    check("rst_pcIFID", pcIFID, 32'h0);
    check("rst_alu", aluEXMEM_Data, 32'h0);
    check("rst_pc_en", {31'h0, pc_en}, 32'h0);
    check("rst_stall_cnt", {28'h0, stall_cnt}, 32'h0);
    check("rst_stall_err", {31'h0, stall_err}, 32'h0);

    // Release; ADDI captured on edge 1, then NOPs are fetched behind it.
    rst_n = 1'b1; stall = 1'b0;
    #1 check("run_pc_en", {31'h0, pc_en}, 32'h1);
    step();
    check("adv_instrIFID", instrIFID, I_ADDI);
    instrIF = 32'h0; pcIF = 32'h8;
    step(); step();
    check("adv_instrEXMEM", instrEXMEM, I_ADDI);
    check("adv_vMEMWB_early", {31'h0, vMEMWB}, 32'h0);
    step();
    check("adv_instrMEMWB", instrMEMWB, I_ADDI);
    check("adv_vMEMWB", {31'h0, vMEMWB}, 32'h1);

    // Load-use: LW then ADD, one stall while ADD sits in IF/ID.
    instrIF = I_LW; pcIF = 32'h10;
    step();
    instrIF = I_ADD; pcIF = 32'h14;
    step();
    stall = 1'b1; instrIF = 32'h2108_0001; pcIF = 32'h18;
    #1 check("lu_pc_en", {31'h0, pc_en}, 32'h0);
    step();
    check("lu_instrIDEX", instrIDEX, 32'h0);
    check("lu_vIDEX", {31'h0, vIDEX}, 32'h0);
    check("lu_instrIFID", instrIFID, I_ADD);
    check("lu_pcIFID", pcIFID, 32'h14);
    check("lu_instrEXMEM", instrEXMEM, I_LW);
    check("lu_stall_cnt", {28'h0, stall_cnt}, 32'h1);
    stall = 1'b0;
    step();
    check("lu_bubble_EXMEM", {instrEXMEM[30:0], vEXMEM}, 32'h0);
    check("lu_add_IDEX", instrIDEX, I_ADD);
    step();
    check("lu_add_EXMEM", instrEXMEM, I_ADD);

    // Branch flush.
    instrIF = I_BR; pcIF = 32'h20;
    step();
    instrIF = 32'h2002_00FF; pcIF = 32'h24; flush = 1'b1;
    step();
    check("fl_vIFID", {31'h0, vIFID}, 32'h0);
    check("fl_instrIFID", instrIFID, 32'h0);
    check("fl_pcIFID", pcIFID, 32'h0);
    check("fl_instrIDEX", instrIDEX, I_BR);
    check("fl_pcIDEX", pcIDEX, 32'h20);
    check("fl_flush_cnt", {28'h0, flush_cnt}, 32'h1);
    flush = 1'b0;

    // Stall and flush together: stall wins.
    instrIF = 32'h2003_0007; pcIF = 32'h40;
    step();
    stall = 1'b1; flush = 1'b1; instrIF = 32'h2004_0008; pcIF = 32'h44;
    step();
    check("sf_instrIFID", instrIFID, 32'h2003_0007);
    check("sf_vIFID", {31'h0, vIFID}, 32'h1);
    check("sf_IDEX_bubble", {instrIDEX[30:0], vIDEX}, 32'h0);
    check("sf_flush_cnt", {28'h0, flush_cnt}, 32'h1);
    check("sf_stall_cnt", {28'h0, stall_cnt}, 32'h2);
    stall = 1'b0; flush = 1'b0;

    // Data path.
    aluEX_Result = 32'hDEAD_BEEF; EX_StoreData = 32'h3; MEM_RdData = 32'h7;
    step();
    check("dp_aluEXMEM", aluEXMEM_Data, 32'hDEAD_BEEF);
    check("dp_data2mem", EXMEM_Data2Mem, 32'h3);
    check("dp_memdata", MEMWB_MemData, 32'h7);
    aluEX_Result = 32'h0000_1234; MEM_RdData = 32'h9;
    step();
    check("dp_aluMEMWB", aluMEMWB_Data, 32'hDEAD_BEEF);
    check("dp_aluEXMEM2", aluEXMEM_Data, 32'h0000_1234);
    check("dp_memdata2", MEMWB_MemData, 32'h9);

    // Runaway: third consecutive stalled edge sets the flag.
    stall = 1'b1;
    step();
    check("rw_err1", {31'h0, stall_err}, 32'h0);
    step();
    check("rw_err2", {31'h0, stall_err}, 32'h0);
    step();
    check("rw_err3", {31'h0, stall_err}, 32'h1);
    stall = 1'b0;
    step();
    check("rw_sticky", {31'h0, stall_err}, 32'h1);
    check("rw_stall_cnt", {28'h0, stall_cnt}, 32'h5);

    // Saturation of the 4-bit stall counter.
    stall = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check("sat_14", {28'h0, stall_cnt}, 32'hE);
    step();
    check("sat_15", {28'h0, stall_cnt}, 32'hF);
    for (int i = 0; i < 10; i++) step();
    check("sat_hold", {28'h0, stall_cnt}, 32'hF);

    // Reset mid-stall clears everything.
    rst_n = 1'b0;
    step();
    check("rst2_err", {31'h0, stall_err}, 32'h0);
    check("rst2_stall_cnt", {28'h0, stall_cnt}, 32'h0);
    check("rst2_flush_cnt", {28'h0, flush_cnt}, 32'h0);
    check("rst2_IFID", {instrIFID[30:0], vIFID}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
